// File: rtl/regfile_arb.sv
// Two-requester arbiter in front of a single-port register file: grant, one access cycle, one ack cycle.
// Build option RFARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed A-over-B priority.
module regfile_arb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              busy,
   output logic              gnt_b
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                lat_we_q, lat_we_d;
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
   logic                gnt_b_q, gnt_b_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                grant_b;

`ifdef RFARB_ROUND_ROBIN_EN
   // prio_b_q set means B wins the next tie; cleared by reset so A goes first.
   logic prio_b_q, prio_b_d;

   assign grant_b = b_req & (~a_req | prio_b_q);

   always_comb begin
      prio_b_d = prio_b_q;
      if (state_q == IDLE && (a_req || b_req)) begin
         prio_b_d = ~grant_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_b_q <= 1'b0;
      end else begin
         prio_b_q <= prio_b_d;
      end
   end
`else
   assign grant_b = b_req & ~a_req;
`endif

   always_comb begin
      state_d     = state_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      gnt_b_d     = gnt_b_q;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               state_d     = ACC;
               gnt_b_d     = grant_b;
               lat_we_d    = grant_b ? b_we    : a_we;
               lat_addr_d  = grant_b ? b_addr  : a_addr;
               lat_wdata_d = grant_b ? b_wdata : a_wdata;
            end
         end
         ACC: begin
            state_d = RESP;
            if (!lat_we_q) begin
               if (gnt_b_q) begin
                  b_rdata_d = rf_rdata;
               end else begin
                  a_rdata_d = rf_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         gnt_b_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         gnt_b_q     <= gnt_b_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   // Gating with reset keeps an interrupted access from writing or acking at that edge.
   assign rf_we    = (state_q == ACC) & lat_we_q & ~reset;
   assign a_ack    = (state_q == RESP) & ~gnt_b_q & ~reset;
   assign b_ack    = (state_q == RESP) & gnt_b_q & ~reset;
   assign rf_addr  = lat_addr_q;
   assign rf_wdata = lat_wdata_q;
   assign busy     = (state_q != IDLE);
   assign gnt_b    = gnt_b_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_regfile_arb.sv
// Bench for regfile_arb: directed scenarios then random traffic against a transaction-level model.
// Expected arbitration follows RFARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_regfile_arb;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ack, b_ack, rf_we, busy, gnt_b;
   logic [DW-1:0] a_rdata, b_rdata, rf_wdata, rf_rdata;
   logic [AW-1:0] rf_addr;

   always #5 clk = ~clk;

   regfile_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .busy(busy), .gnt_b(gnt_b)
   );

   // External register file the DUT drives.
   logic [DW-1:0] rf_mem [0:31];
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
   end

   int checks = 0;
   int failures = 0;

   // Transaction model: an access granted in cycle g uses the file in g+1, acks in g+2, frees at g+3.
   logic [DW-1:0] ref_mem [0:31];
   int            cyc, acc_cyc, ack_cyc, next_free, last_win;
   logic          g_b, g_we, a_done, b_done;
   logic [AW-1:0] g_addr, exp_rf_addr;
   logic [DW-1:0] g_wdata, exp_rf_wdata, exp_a_rdata, exp_b_rdata;
   logic          exp_gnt_b;
   logic [3:0]    exp_ord;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      @(negedge clk);
      cyc++;
      a_done = 1'b0;
      b_done = 1'b0;
      chk1("busy", busy, (cyc == acc_cyc) || (cyc == ack_cyc));
      chk1("rf_we", rf_we, (cyc == acc_cyc) && g_we);
      chk1("a_ack", a_ack, (cyc == ack_cyc) && !g_b);
      chk1("b_ack", b_ack, (cyc == ack_cyc) && g_b);
      chk1("gnt_b", gnt_b, exp_gnt_b);
      chk("rf_addr", 32'(rf_addr), 32'(exp_rf_addr));
      chk("rf_wdata", rf_wdata, exp_rf_wdata);
      chk("a_rdata", a_rdata, exp_a_rdata);
      chk("b_rdata", b_rdata, exp_b_rdata);
      if (cyc == ack_cyc) begin
         $display("txn cyc=%0d req=%s %s addr=%0d data=%08h", cyc, g_b ? "B" : "A",
                  g_we ? "wr" : "rd", g_addr, g_we ? g_wdata : (g_b ? b_rdata : a_rdata));
         if (g_b) b_done = 1'b1;
         else     a_done = 1'b1;
      end
   endtask

   task automatic commit();
      logic win_b;
      if (reset) begin
         acc_cyc = -1; ack_cyc = -1; next_free = cyc + 1; last_win = -1;
         exp_a_rdata = '0; exp_b_rdata = '0; exp_rf_addr = '0; exp_rf_wdata = '0; exp_gnt_b = 1'b0;
      end else begin
         if (cyc == acc_cyc) begin
            if (g_we)     ref_mem[g_addr] = g_wdata;
            else if (g_b) exp_b_rdata = ref_mem[g_addr];
            else          exp_a_rdata = ref_mem[g_addr];
         end
         if (cyc >= next_free && (a_req || b_req)) begin
            win_b = b_req && !a_req;
`ifdef RFARB_ROUND_ROBIN_EN
            if (a_req && b_req) win_b = (last_win == 0);
`endif
            g_b     = win_b;
            g_we    = win_b ? b_we : a_we;
            g_addr  = win_b ? b_addr : a_addr;
            g_wdata = win_b ? b_wdata : a_wdata;
            acc_cyc = cyc + 1; ack_cyc = cyc + 2; next_free = cyc + 3;
            last_win = win_b ? 1 : 0;
            exp_gnt_b = win_b; exp_rf_addr = g_addr; exp_rf_wdata = g_wdata;
         end
      end
   endtask

   task automatic go();
      commit();
      check_cycle();
   endtask

   task automatic drive_random();
      if (cyc == acc_cyc && !g_b) begin
         a_addr = AW'($urandom); a_wdata = $urandom; a_we = 1'($urandom);
      end else if (!a_req || a_done) begin
         a_req = 1'($urandom_range(1, 0));
         a_we = 1'($urandom_range(1, 0)); a_addr = AW'($urandom_range(7, 0)); a_wdata = $urandom;
      end
      if (cyc == acc_cyc && g_b) begin
         b_addr = AW'($urandom); b_wdata = $urandom; b_we = 1'($urandom);
      end else if (!b_req || b_done) begin
         b_req = 1'($urandom_range(1, 0));
         b_we = 1'($urandom_range(1, 0)); b_addr = AW'($urandom_range(7, 0)); b_wdata = $urandom;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      cyc = 0; acc_cyc = -1; ack_cyc = -1; next_free = 0; last_win = -1;
      g_b = 0; g_we = 0; g_addr = '0; g_wdata = '0; a_done = 0; b_done = 0;
      exp_rf_addr = '0; exp_rf_wdata = '0; exp_a_rdata = '0; exp_b_rdata = '0; exp_gnt_b = 0;
`ifdef RFARB_ROUND_ROBIN_EN
      exp_ord = 4'b1010;
`else
      exp_ord = 4'b0000;
`endif
      repeat (2) @(posedge clk);
      check_cycle();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_rf_we", rf_we, 1'b0);
      go();

      // A writes 0xDEADBEEF to register 3
      reset = 0; a_req = 1; a_we = 1; a_addr = 5'd3; a_wdata = 32'hDEAD_BEEF;
      go();
      chk1("wr_rf_we_acc", rf_we, 1'b1);
      chk("wr_rf_addr", 32'(rf_addr), 32'd3);
      go();
      chk1("wr_a_ack", a_ack, 1'b1);
      chk1("wr_rf_we_resp", rf_we, 1'b0);
      chk1("wr_b_ack", b_ack, 1'b0);
      a_req = 0;
      go();
      chk1("wr_a_ack_once", a_ack, 1'b0);

      // B reads register 3
      b_req = 1; b_we = 0; b_addr = 5'd3;
      go();
      chk1("rd_rf_we", rf_we, 1'b0);
      go();
      chk1("rd_b_ack", b_ack, 1'b1);
      chk("rd_b_rdata", b_rdata, 32'hDEAD_BEEF);
      b_req = 0;
      go();
      chk("rd_b_rdata_held", b_rdata, 32'hDEAD_BEEF);

      // Both requesters held for four accesses
      a_req = 1; a_we = 0; a_addr = 5'd3; b_req = 1; b_we = 0; b_addr = 5'd3;
      for (int i = 0; i < 4; i++) begin
         go();
         chk1("tie_order", gnt_b, exp_ord[i]);
         go();
         go();
      end
      a_req = 0;
      go();
      chk1("loser_served", gnt_b, 1'b1);
      go();
      b_req = 0;
      go();

      // Reset during ACC of a B read
      b_req = 1; b_we = 0; b_addr = 5'd3;
      go();
      reset = 1;
      go();
      chk1("rst_acc_busy", busy, 1'b0);
      chk1("rst_acc_b_ack", b_ack, 1'b0);
      chk("rst_acc_b_rdata", b_rdata, 32'd0);
      reset = 0; b_req = 0;
      go();
      chk1("rst_acc_no_late_ack", b_ack, 1'b0);

      // Reset during ACC of an A write: the write must not land
      a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 32'h1234_5678;
      go();
      reset = 1;
      go();
      reset = 0; a_req = 0; b_req = 1; b_we = 0; b_addr = 5'd5;
      go();
      go();
      chk("rst_wr_dropped", b_rdata, 32'd0);
      b_req = 0;
      go();

      // A changes its fields mid-access; the latched address 7 is used
      a_req = 1; a_we = 1; a_addr = 5'd7; a_wdata = 32'hA5A5_0007;
      go();
      chk("chg_rf_addr_acc", 32'(rf_addr), 32'd7);
      a_addr = 5'd9; a_wdata = 32'h9999_9999;
      go();
      chk1("chg_a_ack", a_ack, 1'b1);
      chk("chg_rf_addr_resp", 32'(rf_addr), 32'd7);
      a_we = 0; a_addr = 5'd7;
      go();
      go();
      go();
      chk("chg_readback7", a_rdata, 32'hA5A5_0007);
      a_req = 0; b_req = 1; b_we = 0; b_addr = 5'd9;
      go();
      go();
      chk("chg_addr9_untouched", b_rdata, 32'd0);
      b_req = 0;
      go();

      // Random traffic
      repeat (400) begin
         drive_random();
         go();
      end
      a_req = 0; b_req = 0;
      repeat (4) go();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
